// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer.
// The field-split macros and STARTADDR are global so fetch, decode and
// benches all agree on the bus layout and the reset fetch address.

`ifndef IF_ID_QUEUE_PKG_SV
`define IF_ID_QUEUE_PKG_SV

// First PC issued by fetch after reset.
`define STARTADDR 32'h0000_0034

// Field split of the 64-bit {pc, inst} bus.
`define IF_ID_PC(bus)   (bus[63:32])
`define IF_ID_INST(bus) (bus[31:0])

package if_id_queue_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned IF_ID_BUS_W = PC_W + INST_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_id_t;

  // Build a {pc, inst} bus word.
  function automatic logic [IF_ID_BUS_W-1:0] if_id_pack(input logic [PC_W-1:0]   pc,
                                                        input logic [INST_W-1:0] inst);
    if_id_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

`endif

// File: rtl/if_id_queue.sv
// Instruction buffer between fetch and decode.
// Holds up to DEPTH {pc, inst} entries in arrival order and presents the
// oldest to decode. Occupancy is tracked by a separate count register so
// full/empty never depend on pointer comparison. A flush (redirect or
// exception) empties the queue in one cycle.

module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,

  // Fetch side
  input  logic                   IF_over,
  input  logic [IF_ID_BUS_W-1:0] IF_ID_bus,
  output logic                   push_ready,

  // Decode side
  input  logic                   ID_allow_in,
  output logic                   ID_valid,
  output logic [IF_ID_BUS_W-1:0] ID_bus,

  // Redirect / exception
  input  logic                   flush,

  // Status
  output logic [PTR_W:0]         count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);

  logic [IF_ID_BUS_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wp_q, wp_d;
  logic [PTR_W-1:0]       rp_q, rp_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push, pop;

  // Status decoded from count only; push_ready has no path from ID_allow_in.
  always_comb begin
    full       = (count_q == CntMax);
    empty      = (count_q == '0);
    push_ready = ~full;
    ID_valid   = ~empty;
    count      = count_q;
    ID_bus     = mem_q[rp_q];
  end

  // Accepted handshakes; flush discards both.
  always_comb begin
    push = IF_over & push_ready & ~flush;
    pop  = ID_valid & ID_allow_in & ~flush;
  end

  // Next pointer and occupancy state; flush overrides push and pop.
  always_comb begin
    wp_d    = wp_q + PTR_W'(push);
    rp_d    = rp_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end
  end

  // Pointer and count registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= IF_ID_bus;
    end
  end

  // Occupancy can never exceed the storage size.
  count_le_depth_a : assert property (@(posedge clk) disable iff (reset) count_q <= CntMax);

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a random
// run, all compared against a queue-based model of the buffer.

module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic                   clk;
  logic                   reset;
  logic                   IF_over;
  logic [IF_ID_BUS_W-1:0] IF_ID_bus;
  logic                   push_ready;
  logic                   ID_allow_in;
  logic                   ID_valid;
  logic [IF_ID_BUS_W-1:0] ID_bus;
  logic                   flush;
  logic [PTR_W:0]         count;
  logic                   full;
  logic                   empty;

  if_id_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .IF_over     (IF_over),
    .IF_ID_bus   (IF_ID_bus),
    .push_ready  (push_ready),
    .ID_allow_in (ID_allow_in),
    .ID_valid    (ID_valid),
    .ID_bus      (ID_bus),
    .flush       (flush),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IF_ID_BUS_W-1:0] model_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Compare every DUT output with the model.
  task automatic check_outputs(input string tag);
    int unsigned sz;
    sz = model_q.size();
    check({tag, ".count"},      64'(count),      64'(sz));
    check({tag, ".empty"},      64'(empty),      64'(sz == 0));
    check({tag, ".full"},       64'(full),       64'(sz == DEPTH));
    check({tag, ".push_ready"}, 64'(push_ready), 64'(sz < DEPTH));
    check({tag, ".ID_valid"},   64'(ID_valid),   64'(sz != 0));
    if (sz != 0) check({tag, ".ID_bus"}, ID_bus, model_q[0]);
  endtask

  // Drive one cycle, advance the model by the queue rules, then check.
  task automatic tick(input string tag, input logic ifo, input logic [63:0] bus,
                      input logic allow, input logic fl, input logic rst);
    bit mpush, mpop;
    IF_over     = ifo;
    IF_ID_bus   = bus;
    ID_allow_in = allow;
    flush       = fl;
    reset       = rst;
    mpush = ifo && (model_q.size() < DEPTH) && !fl;
    mpop  = allow && (model_q.size() != 0) && !fl;
    @(posedge clk);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      if (mpop)  void'(model_q.pop_front());
      if (mpush) model_q.push_back(bus);
    end
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [63:0] ent(input int unsigned k);
    return if_id_pack(`STARTADDR + 32'(4 * k), 32'hA000_0000 + 32'(k));
  endfunction

  logic [63:0] tmp;

  initial begin
    IF_over = 0; IF_ID_bus = '0; ID_allow_in = 0; flush = 0; reset = 1;

    // Reset state
    tick("rst", 0, '0, 0, 0, 1);
    check("rst.push_ready_const", 64'(push_ready), 64'd1);

    // 1: three pushes, decode stalled
    for (int k = 0; k < 3; k++) tick("t1", 1, ent(k), 0, 0, 0);
    check("t1.count3", 64'(count), 64'd3);
    tmp = ID_bus;
    check("t1.head_pc", 64'(`IF_ID_PC(tmp)), 64'h34);

    // 2: fill, then push refused while full even though a pop happens
    tick("t2r", 0, '0, 0, 0, 1);
    for (int k = 0; k < 4; k++) tick("t2", 1, ent(k), 0, 0, 0);
    check("t2.full", 64'(full), 64'd1);
    tick("t2.nobypass", 1, ent(4), 1, 0, 0);
    check("t2.count3", 64'(count), 64'd3);
    tick("t2.accept", 1, ent(4), 0, 0, 0);
    check("t2.count4", 64'(count), 64'd4);
    for (int k = 0; k < 4; k++) tick("t2.drain", 0, '0, 1, 0, 0);

    // 3: streaming push+pop across pointer wrap
    tick("t3r", 0, '0, 0, 0, 1);
    tick("t3", 1, ent(0), 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick("t3", 1, ent(k), 1, 0, 0);
      check("t3.count1", 64'(count), 64'd1);
      tmp = ID_bus;
      check("t3.pc", 64'(`IF_ID_PC(tmp)), 64'(32'h34 + 32'(4 * k)));
    end

    // 4: flush with concurrent push and pop
    tick("t4r", 0, '0, 0, 0, 1);
    for (int k = 0; k < 3; k++) tick("t4", 1, ent(k), 0, 0, 0);
    tick("t4.flush", 1, ent(9), 1, 1, 0);
    check("t4.empty", 64'(empty), 64'd1);
    check("t4.count0", 64'(count), 64'd0);
    tick("t4.push", 1, if_id_pack(32'h100, 32'h1234_5678), 0, 0, 0);
    check("t4.head", ID_bus, 64'h0000_0100_1234_5678);

    // 5: reset beats flush mid-stream
    tick("t5r", 0, '0, 0, 0, 1);
    for (int k = 0; k < 2; k++) tick("t5", 1, ent(k), 0, 0, 0);
    tick("t5.rst", 1, ent(5), 1, 1, 1);
    check("t5.count0", 64'(count), 64'd0);
    check("t5.push_ready", 64'(push_ready), 64'd1);

    // 6: random traffic
    tick("t6r", 0, '0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      tick("rnd",
           ($urandom_range(99) < 70),
           {$urandom, $urandom},
           ($urandom_range(99) < 55),
           ($urandom_range(99) < 4),
           ($urandom_range(999) < 5));
      check("rnd.bound", 64'(count <= 3'(DEPTH)), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
